// File: rtl/pio_event_pkg.sv
// Shared constants for the PIO event controller: register addresses and
// parameter defaults used by the top level and the per-bit debouncer.
package pio_event_pkg;

   localparam logic [1:0] ADDR_DATA = 2'd0;
   localparam logic [1:0] ADDR_MASK = 2'd1;
   localparam logic [1:0] ADDR_EDGE = 2'd2;
   localparam logic [1:0] ADDR_POL  = 2'd3;

   localparam int DEF_WIDTH           = 8;
   localparam int DEF_DEBOUNCE_CYCLES = 16;

endpackage

// File: rtl/pio_debounce.sv
// Single-bit input conditioner: 2-flop synchronizer, stability counter,
// debounced level and one-cycle rise/fall pulses following a level change.
module pio_debounce
   import pio_event_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
)(
   input  logic clk,
   input  logic reset_n,
   input  logic in_i,
   output logic deb_o,
   output logic rise_o,
   output logic fall_o
);

   localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             sync1_q;
   logic             sync2_q;
   logic             deb_q;
   logic             deb_d;
   logic             deb_prev_q;
   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   // Count consecutive cycles the synchronized bit differs from the debounced
   // level. For a single bit any change of the synchronized value either makes
   // it equal to the debounced level (clear) or starts a fresh difference from
   // a count of zero, so "equal" alone covers both clear conditions.
   always_comb begin
      cnt_d = '0;
      deb_d = deb_q;
      if (sync2_q != deb_q) begin
         if (cnt_q == CNT_LAST) begin
            deb_d = sync2_q;
         end else begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end
   end

   // Synchronizer, counter and debounced level registers with async clear.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync1_q    <= 1'b0;
         sync2_q    <= 1'b0;
         deb_q      <= 1'b0;
         deb_prev_q <= 1'b0;
         cnt_q      <= '0;
      end else begin
         sync1_q    <= in_i;
         sync2_q    <= sync1_q;
         deb_q      <= deb_d;
         deb_prev_q <= deb_q;
         cnt_q      <= cnt_d;
      end
   end

   assign deb_o  = deb_q;
   assign rise_o = deb_q & ~deb_prev_q;
   assign fall_o = ~deb_q & deb_prev_q;

endmodule

// File: rtl/pio_event_ctrl.sv
// Avalon-MM parallel input port with per-bit debounce, polarity-selected
// edge capture (write-1-to-clear), interrupt mask and a registered irq.
module pio_event_ctrl
   import pio_event_pkg::*;
#(
   parameter int WIDTH           = DEF_WIDTH,
   parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
)(
   input  logic             clk,
   input  logic             reset_n,
   input  logic [1:0]       address,
   input  logic             chipselect,
   input  logic             read,
   input  logic             write,
   input  logic [31:0]      writedata,
   output logic [31:0]      readdata,
   input  logic [WIDTH-1:0] in_port,
   output logic             irq
);

   logic [WIDTH-1:0] deb_w;
   logic [WIDTH-1:0] rise_w;
   logic [WIDTH-1:0] fall_w;
   logic [WIDTH-1:0] edge_det;
   logic [WIDTH-1:0] clr_w;
   logic [WIDTH-1:0] wdata_w;
   logic             wr_en;
   logic             rd_en;
   logic             wdata_unused;

   logic [WIDTH-1:0] mask_q, mask_d;
   logic [WIDTH-1:0] pol_q,  pol_d;
   logic [WIDTH-1:0] edge_q, edge_d;
   logic [31:0]      rdata_q, rdata_d;
   logic             irq_q,  irq_d;

   for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      pio_debounce #(
         .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_deb (
         .clk    (clk),
         .reset_n(reset_n),
         .in_i   (in_port[i]),
         .deb_o  (deb_w[i]),
         .rise_o (rise_w[i]),
         .fall_o (fall_w[i])
      );
   end

   assign wr_en        = chipselect & write;
   assign rd_en        = chipselect & read;
   assign wdata_w      = writedata[WIDTH-1:0];
   assign wdata_unused = ^writedata;
   // Edges come only from debounced level changes, so a polarity write alone
   // can never raise a capture bit.
   assign edge_det     = (rise_w & ~pol_q) | (fall_w & pol_q);
   assign clr_w        = (wr_en && address == ADDR_EDGE) ? wdata_w : '0;

   // Register writes, edge capture with set-over-clear priority, read mux
   // and interrupt; reads see pre-write register values.
   always_comb begin
      mask_d  = mask_q;
      pol_d   = pol_q;
      rdata_d = rdata_q;
      edge_d  = (edge_q & ~clr_w) | edge_det;
      irq_d   = |(edge_q & mask_q);
      if (wr_en) begin
         case (address)
            ADDR_MASK: mask_d = wdata_w;
            ADDR_POL:  pol_d  = wdata_w;
            default:   ;
         endcase
      end
      if (rd_en) begin
         case (address)
            ADDR_DATA: rdata_d = 32'(deb_w);
            ADDR_MASK: rdata_d = 32'(mask_q);
            ADDR_EDGE: rdata_d = 32'(edge_q);
            default:   rdata_d = 32'(pol_q);
         endcase
      end
   end

   // Control/status registers with async clear.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         mask_q  <= '0;
         pol_q   <= '0;
         edge_q  <= '0;
         rdata_q <= '0;
         irq_q   <= 1'b0;
      end else begin
         mask_q  <= mask_d;
         pol_q   <= pol_d;
         edge_q  <= edge_d;
         rdata_q <= rdata_d;
         irq_q   <= irq_d;
      end
   end

   assign readdata = rdata_q;
   assign irq      = irq_q;

endmodule

// File: tb/tb_pio_event_ctrl.sv
// Scoreboard bench for pio_event_ctrl (WIDTH=8, DEBOUNCE_CYCLES=4).
// Timeline with input changed just after edge 0: debounced at edge 6,
// edgecapture at edge 7, irq at edge 8.
module tb_pio_event_ctrl;
   import pio_event_pkg::*;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [1:0]  address;
   logic        chipselect;
   logic        read;
   logic        write;
   logic [31:0] writedata;
   logic [31:0] readdata;
   logic [7:0]  in_port;
   logic        irq;

   typedef struct {
      logic [31:0] rd;
      logic        irq;
      string       name;
   } exp_t;

   exp_t q[$];
   int   tests = 0;
   int   fails = 0;
   logic rvld  = 1'b0;

   pio_event_ctrl #(.WIDTH(8), .DEBOUNCE_CYCLES(4)) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .address   (address),
      .chipselect(chipselect),
      .read      (read),
      .write     (write),
      .writedata (writedata),
      .readdata  (readdata),
      .in_port   (in_port),
      .irq       (irq)
   );

   always #5 clk = ~clk;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic rd(input logic [1:0] a, input logic [31:0] e, input logic ei, input string nm);
      address    = a;
      chipselect = 1'b1;
      read       = 1'b1;
      q.push_back('{e, ei, nm});
      tick();
      chipselect = 1'b0;
      read       = 1'b0;
   endtask

   task automatic wr(input logic [1:0] a, input logic [31:0] d);
      address    = a;
      writedata  = d;
      chipselect = 1'b1;
      write      = 1'b1;
      tick();
      chipselect = 1'b0;
      write      = 1'b0;
   endtask

   task automatic rw(input logic [1:0] a, input logic [31:0] d, input logic [31:0] e,
                     input logic ei, input string nm);
      address    = a;
      writedata  = d;
      chipselect = 1'b1;
      read       = 1'b1;
      write      = 1'b1;
      q.push_back('{e, ei, nm});
      tick();
      chipselect = 1'b0;
      read       = 1'b0;
      write      = 1'b0;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   // Read-response pipe: a read accepted at an edge is presented from then on.
   always @(posedge clk) rvld <= chipselect & read;

   // Monitor: pop the expected response whenever a read response is presented.
   always @(negedge clk) begin
      if (rvld) begin
         if (q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_read: got 0x%08h expected no response", readdata);
         end else begin
            exp_t e;
            e = q.pop_front();
            check({e.name, "_data"}, readdata, e.rd);
            check({e.name, "_irq"}, {31'd0, irq}, {31'd0, e.irq});
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      reset_n    = 1'b0;
      address    = 2'd0;
      chipselect = 1'b0;
      read       = 1'b0;
      write      = 1'b0;
      writedata  = 32'd0;
      in_port    = 8'h00;
      #12;
      check("reset_readdata", readdata, 32'd0);
      check("reset_irq", {31'd0, irq}, 32'd0);
      tick();
      reset_n = 1'b1;
      ticks(3);

      // Reset state of all registers
      rd(ADDR_DATA, 32'h00, 1'b0, "rst_data");
      rd(ADDR_MASK, 32'h00, 1'b0, "rst_mask");
      rd(ADDR_EDGE, 32'h00, 1'b0, "rst_edge");
      rd(ADDR_POL,  32'h00, 1'b0, "rst_pol");
      wr(ADDR_MASK, 32'h01);

      // Rising edge on bit 0: exact debounce/capture/irq latency
      in_port = 8'h01;
      ticks(5);
      rd(ADDR_DATA, 32'h00, 1'b0, "lat_data_early");
      rd(ADDR_DATA, 32'h01, 1'b0, "lat_data");
      rd(ADDR_EDGE, 32'h01, 1'b1, "lat_edge_irq");

      // Three-cycle glitch on bit 3 is rejected
      in_port = 8'h09;
      ticks(3);
      in_port = 8'h01;
      ticks(10);
      rd(ADDR_DATA, 32'h01, 1'b1, "glitch_data");
      rd(ADDR_EDGE, 32'h01, 1'b1, "glitch_edge");
      wr(ADDR_EDGE, 32'h01);
      rd(ADDR_EDGE, 32'h00, 1'b0, "w1c_clear");

      // Polarity writes never set capture bits; falling edge on bit 2
      wr(ADDR_POL, 32'h01);
      wr(ADDR_POL, 32'h04);
      rd(ADDR_EDGE, 32'h00, 1'b0, "polwr_no_edge");
      rd(ADDR_POL,  32'h04, 1'b0, "pol_readback");
      in_port = 8'h05;
      ticks(12);
      rd(ADDR_DATA, 32'h05, 1'b0, "pol_rise_data");
      rd(ADDR_EDGE, 32'h00, 1'b0, "pol_rise_ignored");
      in_port = 8'h01;
      ticks(6);
      rd(ADDR_EDGE, 32'h00, 1'b0, "pol_fall_early");
      rd(ADDR_EDGE, 32'h04, 1'b0, "pol_fall_edge");
      wr(ADDR_EDGE, 32'h04);
      rd(ADDR_EDGE, 32'h00, 1'b0, "pol_clear");

      // Clear coinciding with a new bit-0 edge: set wins
      in_port = 8'h00;
      ticks(12);
      rd(ADDR_DATA, 32'h00, 1'b0, "b0_low");
      in_port = 8'h01;
      ticks(12);
      rd(ADDR_EDGE, 32'h01, 1'b1, "b0_set");
      in_port = 8'h00;
      ticks(12);
      rd(ADDR_DATA, 32'h00, 1'b1, "b0_fall_data");
      in_port = 8'h01;
      ticks(6);
      wr(ADDR_EDGE, 32'h01);
      rd(ADDR_EDGE, 32'h01, 1'b1, "set_wins");
      wr(ADDR_EDGE, 32'h01);
      rd(ADDR_EDGE, 32'h00, 1'b0, "clear_after");

      // Read+write same address returns pre-write; upper data ignored; addr 0 RO
      rw(ADDR_MASK, 32'hABCD_1207, 32'h01, 1'b0, "rw_prewrite");
      rd(ADDR_MASK, 32'h07, 1'b0, "mask_upper_ignored");
      wr(ADDR_DATA, 32'h55);
      rd(ADDR_DATA, 32'h01, 1'b0, "data_ro");
      ticks(2);
      check("readdata_hold", readdata, 32'h01);

      // Reset mid-debounce clears everything and discards the partial count
      rd(ADDR_MASK, 32'h07, 1'b0, "pre_reset_mask");
      in_port = 8'hFF;
      ticks(3);
      reset_n = 1'b0;
      #2;
      check("midrst_readdata", readdata, 32'd0);
      check("midrst_irq", {31'd0, irq}, 32'd0);
      ticks(2);
      reset_n = 1'b1;
      ticks(5);
      rd(ADDR_DATA, 32'h00, 1'b0, "post_rst_data_early");
      rd(ADDR_EDGE, 32'h00, 1'b0, "post_rst_edge_early");
      rd(ADDR_EDGE, 32'hFF, 1'b0, "post_rst_edge");
      wr(ADDR_MASK, 32'hFF);
      rd(ADDR_MASK, 32'hFF, 1'b1, "post_rst_irq");

      ticks(3);
      check("queue_drained", q.size(), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
